// File: rtl/control_unit_seq.sv
// Self-sequencing CPU control unit: owns the FSM state, decodes instr, drives datapath strobes.
// Latency: ALU/LOAD 4 cycles, STORE/JUMP/JUMPZ 3 cycles, plus one cycle per mem_ready=0 in FETCH/MEMORY.
// Backpressure: mem_ready=0 holds FETCH/MEMORY; PAUSE waits for step, HALT_STATE waits for resume.
module control_unit_seq #(
    parameter int INSTR_W = 8,
    parameter int OFF_W   = INSTR_W - 4,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               zf,
    input  logic               mem_ready,
    input  logic               step_mode,
    input  logic               step,
    input  logic               resume,
    output logic [2:0]         state,
    output logic               pc_we,
    output logic               pc_sel,
    output logic [OFF_W-1:0]   pc_offset,
    output logic               addr_sel,
    output logic [OFF_W-1:0]   addr_offset,
    output logic               mem_sel,
    output logic               mem_we,
    output logic [2:0]         alu_opcode,
    output logic               alu_sel_a,
    output logic               alu_sel_b,
    output logic               alu_we,
    output logic               zf_we,
    output logic               ir_we,
    output logic               a_sel,
    output logic               a_we,
    output logic               b_sel,
    output logic               b_we,
    output logic               halt,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        FETCH      = 3'b000,
        DECODE     = 3'b001,
        EXECUTE    = 3'b010,
        MEMORY     = 3'b011,
        WRITEBACK  = 3'b100,
        HALT_STATE = 3'b101,
        PAUSE      = 3'b110,
        ILLEGAL    = 3'b111
    } state_t;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_AND   = 3'b001;
    localparam logic [2:0] OP_NOT   = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_STORE = 3'b100;
    localparam logic [2:0] OP_JUMP  = 3'b101;
    localparam logic [2:0] OP_JUMPZ = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    state_t             state_q;
    state_t             state_d;
    state_t             after_retire;
    logic               retire;
    logic [2:0]         opcode;
    logic               r_sel;
    logic [OFF_W-1:0]   offset;
    logic               is_alu;
    logic               is_jump;

    assign state   = state_q;
    assign opcode  = instr[INSTR_W-1:INSTR_W-3];
    assign r_sel   = instr[INSTR_W-4];
    assign offset  = instr[OFF_W-1:0];
    assign is_alu  = (opcode == OP_ADD) || (opcode == OP_AND) || (opcode == OP_NOT);
    assign is_jump = (opcode == OP_JUMP) || (opcode == OP_JUMPZ);
    // A retiring instruction lands in PAUSE when single-stepping, else straight back to FETCH
    assign after_retire = step_mode ? PAUSE : FETCH;

    // Next-state selection and retire detection (retire also covers the edge into HALT_STATE)
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            FETCH: begin
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEMORY;
                    OP_HALT: begin
                        state_d = HALT_STATE;
                        retire  = 1'b1;
                    end
                    default: state_d = EXECUTE;
                endcase
            end
            EXECUTE: begin
                if (is_jump) begin
                    state_d = after_retire;
                    retire  = 1'b1;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            MEMORY: begin
                if (mem_ready) begin
                    if (opcode == OP_LOAD) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = after_retire;
                        retire  = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                state_d = after_retire;
                retire  = 1'b1;
            end
            HALT_STATE: begin
                if (resume) state_d = after_retire;
            end
            PAUSE: begin
                if (step || !step_mode) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // State register and retired-instruction counter; reset aborts any in-flight instruction
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= FETCH;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            if (retire) instr_count <= instr_count + COUNT_W'(1);
        end
    end

    // Datapath strobes decoded from current state; everything held low while reset is asserted
    always_comb begin
        pc_we       = 1'b0;
        pc_sel      = 1'b0;
        pc_offset   = '0;
        addr_sel    = 1'b0;
        addr_offset = '0;
        mem_sel     = 1'b0;
        mem_we      = 1'b0;
        alu_opcode  = 3'b000;
        alu_sel_a   = 1'b0;
        alu_sel_b   = 1'b0;
        alu_we      = 1'b0;
        zf_we       = 1'b0;
        ir_we       = 1'b0;
        a_sel       = 1'b0;
        a_we        = 1'b0;
        b_sel       = 1'b0;
        b_we        = 1'b0;
        halt        = 1'b0;
        if (reset) begin
            case (state_q)
                FETCH: begin
                    ir_we = mem_ready;
                    pc_we = mem_ready;
                end
                EXECUTE: begin
                    if (is_alu) begin
                        alu_opcode = opcode;
                        alu_we     = 1'b1;
                        zf_we      = 1'b1;
                    end else if (is_jump) begin
                        pc_sel    = 1'b1;
                        pc_offset = offset;
                        pc_we     = (opcode == OP_JUMP) ? 1'b1 : zf;
                    end
                end
                MEMORY: begin
                    addr_sel    = 1'b1;
                    addr_offset = offset;
                    mem_sel     = 1'b1;
                    mem_we      = (opcode == OP_STORE);
                end
                WRITEBACK: begin
                    if (r_sel) begin
                        b_we  = 1'b1;
                        b_sel = (opcode == OP_LOAD);
                    end else begin
                        a_we  = 1'b1;
                        a_sel = (opcode == OP_LOAD);
                    end
                end
                HALT_STATE: halt = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
